// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
//
// Shares one combinational sprite bitmap ROM between NREQ (2..4) sprite
// renderers. Each accepted request becomes a registered single-byte fetch or
// a two-byte row burst, and the data comes back with a one-hot valid that
// tells each renderer which beat is its own.
//
// Build option:
//   SPRITE_ROM_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                                 undefined -> round-robin (default)
//
// Parameters:
//   NREQ  number of requesters (2..4)
//   AW    ROM address width
//   DW    ROM data width
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-high reset
//   req       level-sensitive request per requester
//   addr      packed request addresses, requester i at [i*AW +: AW]
//   blen      burst length per requester (0 = 1 byte, 1 = 2 bytes)
//   gnt       one-hot, one-cycle pulse: request accepted
//   rvalid    one-hot, one-cycle pulse: rdata belongs to that requester
//   rlast     high with the final rvalid of a burst
//   rdata     registered ROM data
//   rom_addr  registered address driven to the ROM
//   rom_data  combinational ROM output
//   busy      high whenever the arbiter is not idle

module sprite_rom_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 8,
    parameter int DW   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ-1:0]    blen,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rvalid,
    output logic               rlast,
    output logic [DW-1:0]      rdata,
    output logic [AW-1:0]      rom_addr,
    input  logic [DW-1:0]      rom_data,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH0,
        FETCH1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [1:0]      owner;
    logic [1:0]      owner_next;
    logic [1:0]      ptr;
    logic [1:0]      ptr_next;
    logic            burst;
    logic            burst_next;
    logic [NREQ-1:0] gnt_next;
    logic [NREQ-1:0] rvalid_next;
    logic            rlast_next;
    logic [DW-1:0]   rdata_next;
    logic [AW-1:0]   rom_addr_next;

    logic            win_valid;
    logic [1:0]      win_idx;
    logic [AW-1:0]   win_addr;
    logic            win_blen;

`ifdef SPRITE_ROM_ARB_FIXED_PRIO_EN
    // Fixed priority: the lowest-numbered asserted request always wins, so
    // the round-robin pointer plays no part in the choice and is never moved.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_valid && req[k]) begin
                win_valid = 1'b1;
                win_idx   = 2'(k);
            end
        end
    end
`else
    logic [3:0] req_ext;
    logic [2:0] cand;

    // Round-robin: walk the requesters starting one past the last winner and
    // take the first one asking. The candidate index is folded back modulo
    // NREQ (not modulo 4) so a three-requester build never looks at a
    // nonexistent slot. The request vector is zero-extended to four bits so
    // the two-bit candidate can index it for any legal NREQ.
    always_comb begin
        req_ext            = '0;
        req_ext[NREQ-1:0]  = req;
        win_valid          = 1'b0;
        win_idx            = '0;
        cand               = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, ptr} + 3'(k);
            if (cand >= 3'(NREQ)) begin
                cand = cand - 3'(NREQ);
            end
            if (!win_valid && req_ext[cand[1:0]]) begin
                win_valid = 1'b1;
                win_idx   = cand[1:0];
            end
        end
    end
`endif

    // Pick out the winner's address and burst length from the packed inputs.
    // Comparing against each legal index keeps every slice in range.
    always_comb begin
        win_addr = '0;
        win_blen = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == 2'(i)) begin
                win_addr = addr[i*AW +: AW];
                win_blen = blen[i];
            end
        end
    end

    // Next-state and next-output logic. Grants, valids and rlast are pulses,
    // so they default to zero every cycle; data, address and ownership hold
    // unless the current state explicitly updates them. Requests are only
    // looked at in IDLE, which is why a requester dropping req mid-burst
    // cannot cut the burst short. The second burst byte always comes from
    // the start address with bit 0 forced high.
    always_comb begin
        state_next    = state;
        owner_next    = owner;
        ptr_next      = ptr;
        burst_next    = burst;
        gnt_next      = '0;
        rvalid_next   = '0;
        rlast_next    = 1'b0;
        rdata_next    = rdata;
        rom_addr_next = rom_addr;

        case (state)
            IDLE: begin
                if (win_valid) begin
                    for (int i = 0; i < NREQ; i++) begin
                        gnt_next[i] = (win_idx == 2'(i));
                    end
                    rom_addr_next = win_addr;
                    owner_next    = win_idx;
                    burst_next    = win_blen;
`ifndef SPRITE_ROM_ARB_FIXED_PRIO_EN
                    ptr_next      = win_idx;
`endif
                    state_next    = FETCH0;
                end
            end

            FETCH0: begin
                rdata_next = rom_data;
                for (int i = 0; i < NREQ; i++) begin
                    rvalid_next[i] = (owner == 2'(i));
                end
                rlast_next = ~burst;
                if (burst) begin
                    rom_addr_next = rom_addr | AW'(1);
                    state_next    = FETCH1;
                end else begin
                    state_next    = IDLE;
                end
            end

            FETCH1: begin
                rdata_next = rom_data;
                for (int i = 0; i < NREQ; i++) begin
                    rvalid_next[i] = (owner == 2'(i));
                end
                rlast_next = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers. Reset drops any fetch in flight, so a
    // requester caught mid-burst never sees its rvalid and has to ask again.
    // The pointer resets to the last index so requester 0 wins the first
    // contest after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= '0;
            ptr      <= 2'(NREQ - 1);
            burst    <= 1'b0;
            gnt      <= '0;
            rvalid   <= '0;
            rlast    <= 1'b0;
            rdata    <= '0;
            rom_addr <= '0;
        end else begin
            state    <= state_next;
            owner    <= owner_next;
            ptr      <= ptr_next;
            burst    <= burst_next;
            gnt      <= gnt_next;
            rvalid   <= rvalid_next;
            rlast    <= rlast_next;
            rdata    <= rdata_next;
            rom_addr <= rom_addr_next;
        end
    end

    // Busy simply reflects that a fetch sequence is under way.
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter
//
// Self-checking bench for sprite_rom_arbiter, built with three requesters so
// the modulo-NREQ pointer wrap is exercised. A behavioural ROM supplies
// rom_data. Expected grants are queued when requests are raised; when a
// grant is observed the matching data beats are queued with the cycle they
// are due, and every observed beat is popped and compared.
// Honours SPRITE_ROM_ARB_FIXED_PRIO_EN for the expected grant order.

module tb_sprite_rom_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 8;
    localparam int DW   = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ-1:0]    blen;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic               rlast;
    logic [DW-1:0]      rdata;
    logic [AW-1:0]      rom_addr;
    logic [DW-1:0]      rom_data;
    logic               busy;

    typedef struct {
        int         idx;
        logic [7:0] a;
        logic       bl;
        int         gap;
    } gnt_exp_t;

    typedef struct {
        logic [NREQ-1:0] rv;
        logic            last;
        logic [7:0]      d;
        int              cyc;
    } beat_t;

    gnt_exp_t gq[$];
    beat_t    bq[$];

    int cyc          = 0;
    int last_gnt_cyc = 0;
    int errors       = 0;
    int checks       = 0;

    sprite_rom_arbiter #(
        .NREQ(NREQ),
        .AW  (AW),
        .DW  (DW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .addr    (addr),
        .blen    (blen),
        .gnt     (gnt),
        .rvalid  (rvalid),
        .rlast   (rlast),
        .rdata   (rdata),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .busy    (busy)
    );

    // Clock: period 10, rising edges at 5, 15, ...; sampling on falling edges.
    always #5 clk = ~clk;

    // Behavioural ROM: an odd multiplier keeps every address distinct.
    function automatic logic [7:0] rom_fn(input logic [7:0] a);
        logic [7:0] m;
        m = a * 8'd37;
        return m ^ 8'hA5;
    endfunction

    assign rom_data = rom_fn(rom_addr);

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Monitor: compares data beats against their due cycle, then compares
    // grants and queues the beats each grant should produce.
    always @(negedge clk) begin : monitor
        beat_t           b;
        gnt_exp_t        g;
        logic [NREQ-1:0] oh;
        cyc++;
        if (bq.size() > 0 && (bq[0].cyc <= cyc || rvalid != '0)) begin
            b = bq.pop_front();
            checkOutput("beat_cycle", 32'(cyc), 32'(b.cyc));
            checkOutput("rvalid", 32'(rvalid), 32'(b.rv));
            checkOutput("rlast", 32'(rlast), 32'(b.last));
            checkOutput("rdata", 32'(rdata), 32'(b.d));
            checkOutput("busy_beat", 32'(busy), 32'(!b.last));
        end else if (rvalid != '0) begin
            checkOutput("rvalid_unexpected", 32'(rvalid), 32'(0));
        end
        if (gnt != '0) begin
            if (gq.size() == 0) begin
                checkOutput("gnt_unexpected", 32'(gnt), 32'(0));
            end else begin
                g  = gq.pop_front();
                oh = '0;
                oh[g.idx] = 1'b1;
                checkOutput("gnt", 32'(gnt), 32'(oh));
                checkOutput("rom_addr", 32'(rom_addr), 32'(g.a));
                checkOutput("busy_gnt", 32'(busy), 32'(1));
                if (g.gap != 0) begin
                    checkOutput("gnt_gap", 32'(cyc - last_gnt_cyc), 32'(g.gap));
                end
                bq.push_back('{rv: oh, last: !g.bl, d: rom_fn(g.a), cyc: cyc + 1});
                if (g.bl) begin
                    bq.push_back('{rv: oh, last: 1'b1, d: rom_fn(g.a | 8'h01), cyc: cyc + 2});
                end
            end
            last_gnt_cyc = cyc;
        end
    end

    task automatic setReq(input int i, input logic [7:0] a, input logic bl, input logic r);
        addr[i*AW +: AW] = a;
        blen[i]          = bl;
        req[i]           = r;
    endtask

    task automatic waitGnt(input int i, output int lat);
        bit found;
        found = 1'b0;
        lat   = 0;
        for (int n = 1; n <= 40 && !found; n++) begin
            @(negedge clk);
            lat = n;
            if (gnt[i]) found = 1'b1;
        end
        if (!found) checkOutput($sformatf("gnt%0d_timeout", i), 32'(0), 32'(1));
    endtask

    task automatic applyStimulus(input int i, input logic [7:0] a, input logic bl,
                                 input int gap, output int lat);
        gq.push_back('{idx: i, a: a, bl: bl, gap: gap});
        setReq(i, a, bl, 1'b1);
        waitGnt(i, lat);
        req[i] = 1'b0;
    endtask

    task automatic waitDrain();
        for (int n = 0; n < 40; n++) begin
            if (gq.size() == 0 && bq.size() == 0 && !busy) break;
            @(negedge clk);
        end
        checkOutput("drain", 32'(gq.size() + bq.size()), 32'(0));
    endtask

    // Holds the given requests high until 'count' grants have been seen.
    task automatic countGrants(input int count, input string tag);
        int n;
        n = 0;
        for (int c = 0; c < 60 && n < count; c++) begin
            @(negedge clk);
            if (gnt != '0) n++;
        end
        req = '0;
        checkOutput(tag, 32'(n), 32'(count));
    endtask

    initial begin
        int lat;
        int exp_idx;
        reset = 1'b1;
        req   = '0;
        addr  = '0;
        blen  = '0;
        repeat (2) @(negedge clk);

        $display("[TB] reset values");
        checkOutput("rst_gnt", 32'(gnt), 32'(0));
        checkOutput("rst_rvalid", 32'(rvalid), 32'(0));
        checkOutput("rst_rlast", 32'(rlast), 32'(0));
        checkOutput("rst_rdata", 32'(rdata), 32'(0));
        checkOutput("rst_rom_addr", 32'(rom_addr), 32'(0));
        checkOutput("rst_busy", 32'(busy), 32'(0));
        reset = 1'b0;

        $display("[TB] first contest after reset");
        gq.push_back('{idx: 0, a: 8'h10, bl: 1'b0, gap: 0});
        gq.push_back('{idx: 1, a: 8'h21, bl: 1'b0, gap: 2});
        setReq(0, 8'h10, 1'b0, 1'b1);
        setReq(1, 8'h21, 1'b0, 1'b1);
        waitGnt(0, lat);
        req[0] = 1'b0;
        checkOutput("first_lat", 32'(lat), 32'(1));
        waitGnt(1, lat);
        req[1] = 1'b0;
        waitDrain();

        $display("[TB] single fetch");
        applyStimulus(0, 8'h23, 1'b0, 0, lat);
        checkOutput("single_lat", 32'(lat), 32'(1));
        waitDrain();

        $display("[TB] burst fetch");
        applyStimulus(1, 8'h44, 1'b1, 0, lat);
        waitDrain();

        $display("[TB] odd-address burst");
        applyStimulus(2, 8'h37, 1'b1, 0, lat);
        waitDrain();

        $display("[TB] contention, both bursting");
        for (int n = 0; n < 6; n++) begin
`ifdef SPRITE_ROM_ARB_FIXED_PRIO_EN
            exp_idx = 0;
`else
            exp_idx = n % 2;
`endif
            gq.push_back('{idx: exp_idx, a: (exp_idx == 0) ? 8'h60 : 8'h72,
                           bl: 1'b1, gap: (n == 0) ? 0 : 3});
        end
        setReq(0, 8'h60, 1'b1, 1'b1);
        setReq(1, 8'h72, 1'b1, 1'b1);
        countGrants(6, "contention_grants");
        waitDrain();

        $display("[TB] pointer wrap");
        applyStimulus(2, 8'h90, 1'b0, 0, lat);
        waitDrain();
        for (int n = 0; n < 3; n++) begin
`ifdef SPRITE_ROM_ARB_FIXED_PRIO_EN
            exp_idx = 0;
`else
            exp_idx = (n == 1) ? 2 : 0;
`endif
            gq.push_back('{idx: exp_idx, a: (exp_idx == 0) ? 8'hA0 : 8'hB1,
                           bl: 1'b0, gap: (n == 0) ? 0 : 2});
        end
        setReq(0, 8'hA0, 1'b0, 1'b1);
        setReq(2, 8'hB1, 1'b0, 1'b1);
        countGrants(3, "wrap_grants");
        waitDrain();

        $display("[TB] reset mid-burst");
        applyStimulus(0, 8'hC4, 1'b1, 0, lat);
        #2 reset = 1'b1;
        #1;
        checkOutput("mr_gnt", 32'(gnt), 32'(0));
        checkOutput("mr_rvalid", 32'(rvalid), 32'(0));
        checkOutput("mr_rlast", 32'(rlast), 32'(0));
        checkOutput("mr_rdata", 32'(rdata), 32'(0));
        checkOutput("mr_rom_addr", 32'(rom_addr), 32'(0));
        checkOutput("mr_busy", 32'(busy), 32'(0));
        bq.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            checkOutput("post_rst_rvalid", 32'(rvalid), 32'(0));
        end

        $display("[TB] contest after mid-burst reset");
        gq.push_back('{idx: 0, a: 8'h11, bl: 1'b0, gap: 0});
        gq.push_back('{idx: 1, a: 8'h22, bl: 1'b0, gap: 2});
        setReq(0, 8'h11, 1'b0, 1'b1);
        setReq(1, 8'h22, 1'b0, 1'b1);
        waitGnt(0, lat);
        req[0] = 1'b0;
        waitGnt(1, lat);
        req[1] = 1'b0;
        waitDrain();

        checkOutput("sb_empty", 32'(gq.size() + bq.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Round-robin arbiter that shares one combinational sprite bitmap ROM (8-bit address, 8-bit data) between up to four sprite renderers, e.g. two or more tank controllers. It sits between the renderers' ROM fetch states and the single `tank_bitmap` instance. It serialises their fetches into registered single-byte or two-byte (row) bursts and returns data with a one-hot valid per requester.

## Interface
- `NREQ`, default 2: number of requesters, legal range 2..4.
- `AW`, default 8: ROM address width.
- `DW`, default 8: ROM data width.

- `clk`  in  1  system clock (25 MHz pixel clock).
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  NREQ  request per requester, level-sensitive.
- `addr`  in  NREQ*AW  packed request addresses; requester i uses bits [i*AW +: AW].
- `blen`  in  NREQ  burst length per requester: 0 = 1 byte, 1 = 2 bytes.
- `gnt`  out  NREQ  one-hot, one-cycle pulse: request accepted.
- `rvalid`  out  NREQ  one-hot, one-cycle pulse: `rdata` is valid for that requester.
- `rlast`  out  1  high with the final `rvalid` of a burst.
- `rdata`  out  DW  registered ROM data.
- `rom_addr`  out  AW  registered address to the ROM.
- `rom_data`  in  DW  combinational ROM output.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- **States:** IDLE, FETCH0, FETCH1.
- **IDLE:**
  - If any `req` is high at a clock edge, select a winner `w` (round-robin, see below).
  - On that edge: `gnt[w]`<=1, `rom_addr`<=addr[w], `owner`<=w, `burst`<=blen[w], `ptr`<=w, state<=FETCH0.
  - If no request is high, all outputs hold and `gnt`/`rvalid` are 0.
- **FETCH0:**
  - `rdata`<=rom_data, `rvalid[owner]`<=1, `rlast`<=~burst.
  - If `burst`=1: `rom_addr`<=rom_addr | 1, state<=FETCH1.
  - If `burst`=0: state<=IDLE.
- **FETCH1:** `rdata`<=rom_data, `rvalid[owner]`<=1, `rlast`<=1, state<=IDLE.
- **Round-robin:**
  - Search starts at index (ptr+1) mod NREQ and ascends with wrap-around.
  - The first asserted `req` wins.
  - `ptr` resets to NREQ-1, so requester 0 wins the first contest.
- **Requester contract:**
  - Hold `req`, `addr` and `blen` stable until `gnt` is seen.
  - Deassert `req` in the cycle `gnt` is high, unless another fetch is wanted.
- **Ignored requests:** `req` is ignored in FETCH0 and FETCH1. Dropping `req` mid-burst does not abort the burst.
- **Burst address rule:** the second byte is always at addr|1. An odd start address therefore re-reads the same byte twice. This is legal and not an error.
- **Widths:**
  - `owner` and `ptr` are 2 bits.
  - Pointer increment wraps modulo NREQ, not modulo 4, when NREQ=3.
- **Reset values:**
  - State IDLE.
  - `gnt`=0, `rvalid`=0, `rlast`=0, `rdata`=0, `rom_addr`=0, `busy`=0.
  - `ptr`=NREQ-1, `owner`=0, `burst`=0.
- **Reset mid-burst:** the in-flight fetch is dropped and no `rvalid` is produced. The requester must re-request after reset.

## Timing
- Edge k (in IDLE, `req[i]` high) produces `gnt[i]` high and new `rom_addr` during cycle k..k+1.
- **Single byte:**
  - `rvalid[i]`, `rlast` and `rdata` are high/valid during cycle k+1..k+2.
  - Latency is 2 edges from request sample to data.
- **Burst:** the first byte is at k+1, the second byte plus `rlast` at k+2.
- **Earliest next grant:** edge k+2 for a single byte, edge k+3 for a burst.
  - Peak throughput is one byte per 2 cycles (single) or two bytes per 3 cycles (burst).
- **Worst-case wait:** with NREQ all bursting, a requester waits at most (NREQ-1)*3 cycles before grant. Four requesters need under 12 cycles, well inside horizontal blanking.
- `busy` is high from edge k to the edge on which state returns to IDLE.

## Configuration
- Macro: `SPRITE_ROM_ARB_FIXED_PRIO_EN`.
- **Defined:** fixed priority. The lowest asserted index always wins and `ptr` is neither updated nor used.
- **Undefined (default):** round-robin as described above.
- All other behaviour and timing are identical in both builds.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle. Response: all outputs 0 immediately and `busy`=0. After release, the first simultaneous req0/req1 grants requester 0.
- **Single fetch:** req0, addr0=0x23, blen0=0. Response: `gnt[0]` at k+1, `rom_addr`=0x23. Then `rvalid[0]`=1, `rlast`=1 and `rdata`=ROM[0x23] at k+2. State returns to IDLE.
- **Burst:** req1, addr1=0x44, blen1=1. Response: `rdata`=ROM[0x44] with `rlast`=0, then `rdata`=ROM[0x45] with `rlast`=1, on consecutive cycles. Only `rvalid[1]` pulses.
- **Contention:** req0 and req1 held high continuously, both with bursts. Response: grants alternate 0,1,0,1 with exactly 3 cycles between grants. Requester 1's request is ignored during requester 0's FETCH states.
- **Wrap with NREQ=3:** req0 and req2 high, `ptr`=2. Response: grant goes to requester 0, then 2, then 0. Requester 1 is never granted and there are no X values on `owner`.
- **Fixed priority build:** with `SPRITE_ROM_ARB_FIXED_PRIO_EN` defined, hold req0 and req1 continuously. Response: only requester 0 is ever granted. Mid-burst reset yields no `rvalid`.
